adder_pipe: RTL
===============

# adder_pipe

Parametrised, pipelined add/subtract unit for the CPU's ALU datapath, generalising the 32-bit ripple-carry adder. The operand width is split into STAGES equal segments. Each pipeline stage adds one segment and registers its carry into the next stage, so a WIDTH-bit add completes in STAGES cycles at one result per cycle. A valid/ready handshake on both sides provides back-pressure toward the execute stage.

## Interface
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth and segment count (1..WIDTH); segment width SEG = WIDTH/STAGES.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 = A - B, 0 = A + B + cin.
- sat  input  1  saturate on signed overflow; present only with ADDER_PIPE_SAT_EN.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts a result.
- sum  output  WIDTH  result.
- cout  output  1  unsigned carry-out; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  any stage holds a valid beat.

## Operation
- Effective operands are computed at intake.
  - Addition: B' = b and C0 = cin.
  - Subtraction: B' = ~b and C0 = 1.
- Stage k (0..STAGES-1) adds segment k of A and B' plus the carry registered by stage k-1 (C0 for k=0). It registers the SEG-bit partial sum and the segment carry.
- Not-yet-processed upper segments of A/B' travel in skew registers alongside the beat. Completed lower sum segments travel with it to the output.
- Each stage has a valid bit. The pipeline advances as a whole on `adv = !out_valid || out_ready`.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- When adv=0, every stage, skew register and output holds its value.
- ovf = carry into MSB XOR carry out of MSB, taken from the final stage. cout = carry out of MSB.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages; their data is don't-care.
- busy = OR of all stage valid bits, including the output stage.
- STAGES=1 degenerates to a single-cycle registered WIDTH-bit adder with the same handshake.

## Timing
- Reset (async assert, sync release): all valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, busy 0. in_ready is 1 from the first clock after reset release.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following that edge, provided adv stays 1. Throughput is 1 beat/cycle.
- out_valid=1 with out_ready=0 stalls the pipeline; sum/cout/ovf remain stable until the handshake completes.
- Simultaneous output accept and input accept in the same cycle is legal; no bubble is inserted.
- Reset asserted mid-operation flushes all in-flight beats immediately. No partial results are emitted after release.
- Carries never combine across more than SEG bits within a cycle; the critical path is a SEG-bit ripple.

## Configuration
- ADDER_PIPE_SAT_EN: when defined, the sat port exists and is carried with the beat.
  - If sat=1 and ovf=1 on output, sum is clamped to 0x7F..F when the true result is positive (A' MSB = 0), else to 0x80..0.
  - ovf and cout still report the raw, pre-clamp condition.
- When not defined, there is no sat port and sum is always the raw modular result.

## Test plan
- WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=1, add -> sum=0x80000000, cout=0, ovf=1; with ADDER_PIPE_SAT_EN and sat=1 -> sum=0x7FFFFFFF, ovf=1.
- a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> sum=2, cout=1.
- 8 back-to-back beats (a=i, b=i<<16), out_ready held 0 for cycles 6-9:
  - in_ready=0 during the stall;
  - all 8 results emerge in order with no loss or duplication;
  - busy drops 1 cycle after the last result is accepted.
- 3 beats in flight, rst pulsed mid-cycle -> out_valid, busy and sum go to 0 immediately; no stale result after release.
- WIDTH=8, STAGES=1: a=0x80, b=0x80 -> next-cycle sum=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract. Each of the STAGES stages ripples one SEG-bit segment and registers the segment carry.
// Optional signed saturation is built in when ADDER_PIPE_SAT_EN is defined. Latency is STAGES edges and throughput is one beat per cycle.
// The whole pipe advances only when the output is empty or is being taken, so in_ready = !out_valid || out_ready.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef ADDER_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int SEG = WIDTH / STAGES;

    // One beat as it travels down the pipe: skewed operands, partial sum, running carry.
    typedef struct packed {
        logic             vld;
        logic             sat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
    } beat_t;

    beat_t          intake;
    beat_t          prev [STAGES];
    beat_t          st_d [STAGES];
    beat_t          st_q [STAGES];
    logic [SEG:0]   seg_sum;
    logic           adv;

    assign out_valid = st_q[STAGES-1].vld;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_comb begin
        intake     = '0;
        intake.vld = in_valid;
        intake.a   = a;
        intake.b   = sub ? ~b : b;
        intake.c   = sub | cin;
`ifdef ADDER_PIPE_SAT_EN
        intake.sat = sat;
`else
        intake.sat = 1'b0;
`endif
    end

    always_comb begin
        prev[0] = intake;
        for (int k = 1; k < STAGES; k++) begin
            prev[k] = st_q[k-1];
        end
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, prev[k].a[k*SEG +: SEG]}
                    + {1'b0, prev[k].b[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, prev[k].c};
            st_d[k]                  = prev[k];
            st_d[k].s[k*SEG +: SEG]  = seg_sum[SEG-1:0];
            st_d[k].c                = seg_sum[SEG];
            // Carry into the segment MSB is recovered from its sum bit; only the last stage's value is used.
            st_d[k].ovf = seg_sum[SEG]
                        ^ (prev[k].a[k*SEG+SEG-1] ^ prev[k].b[k*SEG+SEG-1] ^ seg_sum[SEG-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy = busy | st_q[k].vld;
        end
    end

    assign cout = st_q[STAGES-1].c;
    assign ovf  = st_q[STAGES-1].ovf;

    always_comb begin
        sum = st_q[STAGES-1].s;
`ifdef ADDER_PIPE_SAT_EN
        // The clamp direction follows A's sign, because overflow means both operands share that sign.
        if (st_q[STAGES-1].sat && st_q[STAGES-1].ovf) begin
            sum = {st_q[STAGES-1].a[WIDTH-1], {(WIDTH-1){~st_q[STAGES-1].a[WIDTH-1]}}};
        end
`endif
    end

endmodule
